// File: rtl/rv_alu_pkg.sv
// rtl/rv_alu_pkg.sv - shared RV32I OP/OP-IMM encodings and legality check
// Purpose: opcode, func3 and funct7 constants plus the decode legality
//          function used by the issue stage.
package rv_alu_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } func3_e;

    // Only the subset the attached ALU executes is legal: no arithmetic
    // right shifts, and the register-form func3=101 is rejected outright.
    function automatic logic rv_is_legal(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                ok = ((instr[31:25] == FUNCT7_ZERO) && (instr[14:12] != F3_SRL)) ||
                     ((instr[31:25] == FUNCT7_SUB)  && (instr[14:12] == F3_ADD));
            end
            OPC_OPIMM: begin
                ok = (instr[14:12] != F3_SRL) || (instr[31:25] == FUNCT7_ZERO);
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv_alu_issue_regfile.sv
// rtl/rv_alu_issue_regfile.sv - 32x32 register file, two read ports, debug read, one write
// Purpose: integer register file with x0 hard-wired to zero.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all entries
//   i_ra1/o_rd1           read port 1 (combinational)
//   i_ra2/o_rd2           read port 2 (combinational)
//   i_dbg_addr/o_dbg_data debug read port (combinational)
//   i_we/i_wa/i_wd        synchronous write port; writes to x0 are dropped
module rv_regfile_2r1w (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra1,
    output logic [31:0] o_rd1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd2,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1      = (i_ra1 == 5'd0)      ? 32'd0 : r_mem[i_ra1];
    assign o_rd2      = (i_ra2 == 5'd0)      ? 32'd0 : r_mem[i_ra2];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/rv_alu_issue.sv
// rtl/rv_alu_issue.sv - issue/writeback stage around a combinational RV32I ALU
// Purpose: accepts OP/OP-IMM instructions, reads operands with EX bypass,
//          holds one instruction in EX driving the ALU, writes alu_y back.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr instruction handshake (in_ready = ~stall)
//   stall                      freezes EX and blocks accepts
//   alu_x1/alu_x2/alu_instr    ALU operands and instruction field [31:12]
//   alu_opcode_4/alu_cin       constant ALU controls
//   alu_y                      ALU result
//   wb_valid/wb_rd/wb_data     retire pulse with destination and value
//   illegal                    pulse on a rejected instruction
//   retired_cnt/illegal_cnt    saturating event counters
//   dbg_addr/dbg_data          register file debug read
module rv_alu_issue
    import rv_alu_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter logic [31:0] RST_PC_TAG = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             stall,
    output logic [31:0]      alu_x1,
    output logic [31:0]      alu_x2,
    output logic [19:0]      alu_instr,
    output logic             alu_opcode_4,
    output logic             alu_cin,
    input  logic [31:0]      alu_y,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_is_op;
    logic        w_is_sub;
    logic        w_legal;
    logic        w_accept;
    logic        w_wb_fire;
    logic        w_hit1;
    logic        w_hit2;
    logic [31:0] w_rf1;
    logic [31:0] w_rf2;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_op2;
    logic [19:0] w_alu_instr;

    logic             r_ex_valid;
    logic [4:0]       r_ex_rd;
    logic [31:0]      r_x1;
    logic [31:0]      r_x2;
    logic [19:0]      r_instr;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;
    logic             r_illegal;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    assign w_opc = in_instr[6:0];
    assign w_rd  = in_instr[11:7];
    assign w_f3  = in_instr[14:12];
    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];
    assign w_f7  = in_instr[31:25];

    assign w_is_op  = (w_opc == OPC_OP);
    assign w_is_sub = w_is_op && (w_f7 == FUNCT7_SUB) && (w_f3 == F3_ADD);
    assign w_legal  = rv_is_legal(in_instr);

    assign in_ready  = ~stall;
    assign w_accept  = in_valid & ~stall;
    assign w_wb_fire = r_ex_valid & ~stall;

    rv_regfile_2r1w u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ra1      (w_rs1),
        .o_rd1      (w_rf1),
        .i_ra2      (w_rs2),
        .o_rd2      (w_rf2),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .i_we       (w_wb_fire),
        .i_wa       (r_ex_rd),
        .i_wd       (alu_y)
    );

    // The EX result is written on the same edge this read is captured, so
    // a matching rd must come from alu_y, not the not-yet-updated array.
    assign w_hit1 = r_ex_valid && (r_ex_rd != 5'd0) && (r_ex_rd == w_rs1);
    assign w_hit2 = r_ex_valid && (r_ex_rd != 5'd0) && (r_ex_rd == w_rs2);
    assign w_src1 = w_hit1 ? alu_y : w_rf1;
    assign w_src2 = w_hit2 ? alu_y : w_rf2;

    // Immediate form also carries shamt in bits [4:0].
    assign w_op2 = w_is_op ? w_src2 : {{20{in_instr[31]}}, in_instr[31:20]};

    // The ALU subtracts only when instruction bit 30 is clear, so every
    // non-SUB operation drives it high.
    assign w_alu_instr = {1'b0, ~w_is_sub, 15'd0, w_f3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_instr    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_illegal  <= 1'b0;
            r_ret_cnt  <= '0;
            r_ill_cnt  <= '0;
        end else if (stall) begin
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_ex_valid <= w_accept & w_legal;
            if (w_accept && w_legal) begin
                r_ex_rd <= w_rd;
                r_x1    <= w_src1;
                r_x2    <= w_op2;
                r_instr <= w_alu_instr;
            end

            r_wb_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_wb_rd   <= r_ex_rd;
                r_wb_data <= alu_y;
                if (r_ret_cnt != CNT_MAX) begin
                    r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                end
            end

            r_illegal <= w_accept & ~w_legal;
            if (w_accept && !w_legal && (r_ill_cnt != CNT_MAX)) begin
                r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            end
        end
    end

    assign alu_x1       = r_x1;
    assign alu_x2       = r_x2;
    assign alu_instr    = r_instr;
    assign alu_opcode_4 = 1'b1;
    assign alu_cin      = 1'b0;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign illegal      = r_illegal;
    assign retired_cnt  = r_ret_cnt;
    assign illegal_cnt  = r_ill_cnt;

endmodule

// File: tb/tb_rv_alu_issue.sv
// tb/tb_rv_alu_issue.sv - self-checking bench for rv_alu_issue
module tb_rv_alu_issue;

    localparam int CW     = 4;
    localparam int CW_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          stall;
    logic [31:0]   alu_x1;
    logic [31:0]   alu_x2;
    logic [19:0]   alu_instr;
    logic          alu_opcode_4;
    logic          alu_cin;
    logic [31:0]   alu_y;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          illegal;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] illegal_cnt;
    logic [4:0]    dbg_addr;
    logic [31:0]   dbg_data;

    rv_alu_issue #(.CNT_W(CW), .RST_PC_TAG(32'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .stall        (stall),
        .alu_x1       (alu_x1),
        .alu_x2       (alu_x2),
        .alu_instr    (alu_instr),
        .alu_opcode_4 (alu_opcode_4),
        .alu_cin      (alu_cin),
        .alu_y        (alu_y),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .illegal      (illegal),
        .retired_cnt  (retired_cnt),
        .illegal_cnt  (illegal_cnt),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_y = 32'd0;
        case (alu_instr[2:0])
            3'd0: alu_y = alu_instr[18] ? alu_x1 + alu_x2 : alu_x1 - alu_x2;
            3'd1: alu_y = alu_x1 << alu_x2[4:0];
            3'd2: alu_y = {31'd0, $signed(alu_x1) < $signed(alu_x2)};
            3'd3: alu_y = {31'd0, alu_x1 < alu_x2};
            3'd4: alu_y = alu_x1 ^ alu_x2;
            3'd5: alu_y = alu_x1 >> alu_x2[4:0];
            3'd6: alu_y = alu_x1 | alu_x2;
            default: alu_y = alu_x1 & alu_x2;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural reference state
    logic [31:0] m_regs [32];
    bit          m_ex_v;
    logic [4:0]  m_ex_rd;
    logic [31:0] m_ex_res;
    logic [31:0] m_ex_x1;
    logic [31:0] m_ex_x2;
    logic [19:0] m_ex_ins;
    int          m_ret;
    int          m_ill;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ex_v = 0;
        m_ret  = 0;
        m_ill  = 0;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // What an RV32I machine restricted to this subset would do.
    task automatic ref_exec(input logic [31:0] ins, output bit legal,
                            output logic [31:0] x1, output logic [31:0] x2,
                            output logic [31:0] res, output logic [19:0] ains);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         is_op;
        bit         is_imm;
        bit         sub;
        opc    = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        is_op  = (opc == 7'b0110011);
        is_imm = (opc == 7'b0010011);
        if (is_op)
            legal = (f7 == 7'd0 && f3 != 3'd5) || (f7 == 7'h20 && f3 == 3'd0);
        else if (is_imm)
            legal = (f3 != 3'd5) || (f7 == 7'd0);
        else
            legal = 0;
        sub = is_op && (f7 == 7'h20) && (f3 == 3'd0);
        x1  = m_regs[ins[19:15]];
        x2  = is_op ? m_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
        case (f3)
            3'd0: res = sub ? x1 - x2 : x1 + x2;
            3'd1: res = x1 << x2[4:0];
            3'd2: res = ($signed(x1) < $signed(x2)) ? 32'd1 : 32'd0;
            3'd3: res = (x1 < x2) ? 32'd1 : 32'd0;
            3'd4: res = x1 ^ x2;
            3'd5: res = x1 >> x2[4:0];
            3'd6: res = x1 | x2;
            default: res = x1 & x2;
        endcase
        ains = 20'd0;
        ains[2:0] = f3;
        ains[18]  = !sub;
    endtask

    // One clock: drive, model the edge, then compare on the falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic st);
        bit          exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_ill;
        bit          legal;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] res;
        logic [19:0] ains;
        in_valid = v;
        in_instr = ins;
        stall    = st;
        exp_wb   = 0;
        exp_ill  = 0;
        exp_rd   = 5'd0;
        exp_data = 32'd0;
        @(posedge clk);
        if (!st) begin
            if (m_ex_v) begin
                exp_wb   = 1;
                exp_rd   = m_ex_rd;
                exp_data = m_ex_res;
                if (m_ex_rd != 5'd0) m_regs[m_ex_rd] = m_ex_res;
                if (m_ret < CW_MAX) m_ret++;
            end
            m_ex_v = 0;
            if (v) begin
                ref_exec(ins, legal, x1, x2, res, ains);
                if (legal) begin
                    m_ex_v   = 1;
                    m_ex_rd  = ins[11:7];
                    m_ex_res = res;
                    m_ex_x1  = x1;
                    m_ex_x2  = x2;
                    m_ex_ins = ains;
                end else begin
                    exp_ill = 1;
                    if (m_ill < CW_MAX) m_ill++;
                end
            end
        end
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!st));
        check("wb_valid", 32'(wb_valid), 32'(exp_wb));
        if (exp_wb) begin
            check("wb_rd", 32'(wb_rd), 32'(exp_rd));
            check("wb_data", wb_data, exp_data);
        end
        check("illegal", 32'(illegal), 32'(exp_ill));
        check("retired_cnt", 32'(retired_cnt), 32'(m_ret));
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
        check("alu_opcode_4", 32'(alu_opcode_4), 32'd1);
        check("alu_cin", 32'(alu_cin), 32'd0);
        if (m_ex_v) begin
            check("alu_x1", alu_x1, m_ex_x1);
            check("alu_x2", alu_x2, m_ex_x2);
            check("alu_instr", 32'(alu_instr), 32'(m_ex_ins));
        end
    endtask

    task automatic check_regs();
        for (int r = 0; r < 32; r++) begin
            dbg_addr = r[4:0];
            #1;
            check($sformatf("dbg_x%0d", r), dbg_data, m_regs[r]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_retired_cnt", 32'(retired_cnt), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_alu_x1", alu_x1, 32'd0);
        check("rst_alu_x2", alu_x2, 32'd0);
        check("rst_alu_instr", 32'(alu_instr), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        int          sel;
        logic [31:0] rnd;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        k   = $urandom_range(0, 9);
        rnd = $urandom();
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        if (k < 4) begin
            sel = $urandom_range(0, 9);
            f7  = (sel < 6) ? 7'd0 : (sel < 9) ? 7'h20 : rnd[31:25];
            return enc_r(f7, rs2, rs1, f3, rd);
        end else if (k < 8) begin
            imm = rnd[11:0];
            sel = $urandom_range(0, 3);
            if (sel == 0) imm[11:5] = 7'd0;
            if (sel == 1) imm[11:5] = 7'h20;
            return enc_i(imm, rs1, f3, rd);
        end else begin
            opc = rnd[6:0];
            if (opc == 7'b0110011 || opc == 7'b0010011) opc = 7'b0000011;
            return {rnd[31:7], opc};
        end
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'd0;
        stall    = 1'b0;
        dbg_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Back-to-back with bypass, SUB, negative immediate
        cycle(1, enc_i(12'd5, 5'd0, 3'd0, 5'd1), 0);
        cycle(1, enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2), 0);
        cycle(1, enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd3), 0);
        cycle(1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd4), 0);
        // Shifts: SRLI legal, SRAI and a load rejected
        cycle(1, enc_i(12'h004, 5'd4, 3'd5, 5'd5), 0);
        cycle(1, enc_i(12'h404, 5'd4, 3'd5, 5'd5), 0);
        cycle(1, {12'd0, 5'd0, 3'd2, 5'd7, 7'b0000011}, 0);
        // Write to x0 still retires
        cycle(1, enc_i(12'd7, 5'd0, 3'd0, 5'd0), 0);
        cycle(0, 32'd0, 0);
        check("x5_srli", m_regs[5], 32'h0FFFFFFF);
        check_regs();

        // Stall with ADD in EX; an input offered while stalled is ignored
        cycle(1, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd6), 0);
        cycle(1, enc_i(12'd1, 5'd6, 3'd0, 5'd7), 1);
        cycle(0, 32'd0, 1);
        cycle(0, 32'd0, 1);
        cycle(0, 32'd0, 0);
        cycle(0, 32'd0, 0);

        // Randomised traffic, counters saturate along the way
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 4) == 0));
        end
        cycle(0, 32'd0, 0);
        check_regs();

        // Reset while ADDI x6,x0,9 sits in EX
        cycle(1, enc_i(12'd9, 5'd0, 3'd0, 5'd6), 0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_outputs();
        check_regs();
        cycle(1, enc_i(12'd9, 5'd0, 3'd0, 5'd6), 0);
        cycle(0, 32'd0, 0);
        check_regs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
